calc_op_sequencer: RTL



---
 rtl/calc_op_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/calc_op_sequencer.sv
// Transaction front end for the combinational calculator datapath: accepts a request,
// drives the datapath, waits a settle time and returns the result. Optional: CALC_ERR_STICKY_EN.
module calc_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] CMD_MASK      = 16'h003E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [15:0] dp_inputA,
  output logic [15:0] dp_inputB,
  output logic [3:0]  dp_command,
  input  logic [31:0] dp_result,
  input  logic        dp_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_error,
  output logic [3:0]  rsp_cmd,
`ifdef CALC_ERR_STICKY_EN
  input  logic        err_clr,
  output logic        err_sticky,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dp_a_q, dp_a_d;
  logic [15:0] dp_b_q, dp_b_d;
  logic [3:0]  dp_cmd_q, dp_cmd_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_error_q, rsp_error_d;
  logic [3:0]  rsp_cmd_q, rsp_cmd_d;
  logic        is_div;

  assign is_div = (req_cmd == 4'd4) || (req_cmd == 4'd5);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_cmd_d     = dp_cmd_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    rsp_cmd_d    = rsp_cmd_q;
    req_ready    = (state_q == StIdle) && !rst;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          rsp_cmd_d    = req_cmd;
          rsp_result_d = '0;
          rsp_error_d  = 1'b0;
          if (req_cmd == 4'd0) begin
            state_d = StResp;
          end else if (!CMD_MASK[req_cmd]) begin
            rsp_error_d = 1'b1;
            state_d     = StResp;
          end else if (is_div && (req_b == 16'd0)) begin
            // Division by zero is answered locally; the datapath never sees it.
            rsp_result_d = 32'hFFFF_FFFF;
            rsp_error_d  = 1'b1;
            state_d      = StResp;
          end else begin
            dp_a_d   = req_a;
            dp_b_d   = req_b;
            dp_cmd_d = req_cmd;
            cnt_d    = 4'(SETTLE_CYCLES);
            state_d  = StSettle;
          end
        end
      end
      StSettle: begin
        if (cnt_q <= 4'd1) begin
          rsp_result_d = dp_result;
          rsp_error_d  = dp_error;
          dp_cmd_d     = 4'd0;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_cmd_q     <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      rsp_cmd_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_cmd_q     <= dp_cmd_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      rsp_cmd_q    <= rsp_cmd_d;
    end
  end

  assign dp_inputA  = dp_a_q;
  assign dp_inputB  = dp_b_q;
  assign dp_command = dp_cmd_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_cmd    = rsp_cmd_q;
  assign busy       = (state_q != StIdle);

`ifdef CALC_ERR_STICKY_EN
  logic err_sticky_q;

  // Set wins over clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else if (rsp_valid && rsp_ready && rsp_error_q) begin
      err_sticky_q <= 1'b1;
    end else if (err_clr) begin
      err_sticky_q <= 1'b0;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule
